data_sram_responder: RTL and testbench

//  Responder (slave) end of the data-side SRAM-like interface driven by the execute stage.

---
 rtl/data_sram_responder_pkg.sv | 29 ++
 rtl/data_sram_responder_if.sv | 27 ++
 rtl/data_sram_responder_req_fifo.sv | 55 +++++
 rtl/data_sram_responder.sv | 147 ++++++++++++++
 tb/tb_data_sram_responder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared types for the data-side SRAM responder: access-size encodings,
// responder FSM states and the queued request entry.
package data_sram_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_B    = 2'd0,
    SIZE_H    = 2'd1,
    SIZE_W    = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Full word index (addr[31:2]); the responder uses only its low ADDR_W bits.
  localparam int unsigned IDX_W = 30;

  typedef struct packed {
    logic             wr;
    size_e            size;
    logic [IDX_W-1:0] idx;
    logic [3:0]       wstrb;
    logic [31:0]      wdata;
  } req_entry_t;

endpackage

// File: rtl/data_sram_responder_if.sv
// Data-side SRAM-like bus between the execute stage (master) and the
// data memory responder (slave).
interface data_sram_responder_if;

  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

endinterface

// File: rtl/data_sram_responder_req_fifo.sv
// In-order request queue for the data SRAM responder: DEPTH entries,
// synchronous push/pop, head entry always visible, occupancy count.
module dsram_req_fifo
  import data_sram_responder_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  req_entry_t       push_data,
  input  logic             pop,
  output req_entry_t       head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_entry_t       slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; push and pop in one cycle keep count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= advance(wr_ptr);
      if (pop)  rd_ptr <= advance(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  // Head of queue drives the responder FSM.
  always_comb begin
    head = slots[rd_ptr];
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: accepts requests into an in-order queue and answers
// each with a one-cycle data_ok pulse a fixed latency after it reaches the
// queue head, backed by a word-organised memory with byte-lane writes.
// Optional macro DSRAM_STALL_INJECT_EN adds LFSR-driven pseudo-random stalls
// on acceptance and on the latency countdown.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned Q_DEPTH  = 2,
  parameter int unsigned RESP_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_sram_responder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);
  localparam int unsigned LAT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(RESP_LAT - 1);

  logic [31:0]       mem [0:(1 << ADDR_W) - 1];
  logic [CNT_W-1:0]  count;
  req_entry_t        head;
  req_entry_t        push_entry;
  logic              push;
  logic              pop;
  logic              addr_ok;
  logic              accept_gate;
  logic              wait_go;
  logic [ADDR_W-1:0] head_idx;
  state_e            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic              data_ok;
  logic [31:0]       rdata;
  logic              unused_bits;

`ifdef DSRAM_STALL_INJECT_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, free-running, supplies stall decisions.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Stall gates taken from the low LFSR bits.
  always_comb begin
    accept_gate = lfsr[0];
    wait_go     = lfsr[1];
  end
`else
  // No stall injection: acceptance and countdown never held.
  always_comb begin
    accept_gate = 1'b1;
    wait_go     = 1'b1;
  end
`endif

  // Acceptance uses the registered count only, so a slot retiring this cycle
  // is not reusable until the next one.
  always_comb begin
    addr_ok          = !reset && (count < CNT_W'(Q_DEPTH)) && accept_gate;
    push             = bus.data_sram_req && addr_ok;
    pop              = (state == RESP);
    head_idx         = head.idx[ADDR_W-1:0];
    push_entry       = '0;
    push_entry.wr    = bus.data_sram_wr;
    push_entry.size  = size_e'(bus.data_sram_size);
    push_entry.idx   = bus.data_sram_addr[31:2];
    push_entry.wstrb = bus.data_sram_wstrb;
    push_entry.wdata = bus.data_sram_wdata;
    unused_bits      = ^{head.size, head.idx[IDX_W-1:ADDR_W], bus.data_sram_addr[1:0]};
  end

  dsram_req_fifo #(
    .DEPTH(Q_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Head-of-queue FSM: count down the latency, then pulse data_ok for one
  // cycle with read data captured on the edge entering RESP. The RESP exit
  // looks at the registered count, so an entry pushed during RESP into an
  // otherwise empty queue restarts from IDLE and keeps the full latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= '0;
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      data_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state   <= WAIT;
            lat_cnt <= LAT_RELOAD;
          end
        end
        WAIT: begin
          if (wait_go) begin
            if (lat_cnt == '0) begin
              state   <= RESP;
              data_ok <= 1'b1;
              if (!head.wr) rdata <= mem[head_idx];
            end else begin
              lat_cnt <= lat_cnt - 1'b1;
            end
          end
        end
        RESP: begin
          if (count > CNT_W'(1)) begin
            state   <= WAIT;
            lat_cnt <= LAT_RELOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-lane write of the head entry while it is being answered.
  always_ff @(posedge clk) begin
    if (!reset && (state == RESP) && head.wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (head.wstrb[i]) mem[head_idx][8*i +: 8] <= head.wdata[8*i +: 8];
      end
    end
  end

  // Registered response outputs onto the bus.
  always_comb begin
    bus.data_sram_addr_ok = addr_ok;
    bus.data_sram_data_ok = data_ok;
    bus.data_sram_rdata   = rdata;
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: stimulus pushes expected
// responses at acceptance, a negedge monitor pops and compares on data_ok.
module tb_data_sram_responder;

  localparam int ADDR_W   = 10;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int RESP_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  data_sram_responder_if bus ();

  data_sram_responder #(
    .ADDR_W   (ADDR_W),
    .Q_DEPTH  (2),
    .RESP_LAT (RESP_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          seq;
    bit          check_data;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] ref_mem [int];
  int          resp_at [int];
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          last_resp = -100;
  int          spurious  = 0;
  int          next_seq  = 0;
  logic [31:0] last_rdata = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // Monitor: every data_ok must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    int   want;
    if (!reset && bus.data_sram_data_ok) begin
      if (sb.size() == 0) begin
        spurious++;
        n_checks++;
        n_fail++;
        $display("FAIL spurious_data_ok: got data_ok=1 at cycle %0d expected no response", cyc);
      end else begin
        e = sb.pop_front();
        resp_at[e.seq] = cyc;
`ifndef DSRAM_STALL_INJECT_EN
        want = (e.acc + RESP_LAT + 1 > last_resp + RESP_LAT + 1) ? e.acc + RESP_LAT + 1
                                                                 : last_resp + RESP_LAT + 1;
        check("resp_cycle", 32'(cyc), 32'(want));
`endif
        last_resp = cyc;
        if (e.check_data) begin
          check("rdata", bus.data_sram_rdata, e.data);
          last_rdata = bus.data_sram_rdata;
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [3:0] wstrb, input logic [31:0] wdata,
                       output int seq, output int acc);
    int   tries = 0;
    bit   done  = 1'b0;
    int   w;
    exp_t e;
    @(negedge clk);
    bus.data_sram_req   = 1'b1;
    bus.data_sram_wr    = wr;
    bus.data_sram_size  = size;
    bus.data_sram_addr  = addr;
    bus.data_sram_wstrb = wstrb;
    bus.data_sram_wdata = wdata;
    while (!done && tries <= 50) begin
      #1;
      if (bus.data_sram_addr_ok) done = 1'b1;
      else begin
        tries++;
        @(negedge clk);
      end
    end
    seq = -1;
    acc = -1;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no addr_ok in 50 cycles expected acceptance");
      bus.data_sram_req = 1'b0;
    end else begin
      w   = word_of(addr);
      acc = cyc + 1;
      seq = next_seq++;
      e.seq = seq;
      e.acc = acc;
      e.check_data = 1'b0;
      e.data = '0;
      if (wr) begin
        if (ref_mem.exists(w)) begin
          for (int i = 0; i < 4; i++)
            if (wstrb[i]) ref_mem[w][8*i +: 8] = wdata[8*i +: 8];
        end else if (wstrb == 4'hF) begin
          ref_mem[w] = wdata;
        end
      end else if (ref_mem.exists(w)) begin
        e.check_data = 1'b1;
        e.data = ref_mem[w];
      end
      sb.push_back(e);
    end
  endtask

  task automatic quiesce();
    int n = 0;
    @(negedge clk);
    bus.data_sram_req = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, s2, a0, a1, a2, k;
    logic [31:0] a;

    reset = 1'b1;
    bus.data_sram_req   = 1'b1;
    bus.data_sram_wr    = 1'b0;
    bus.data_sram_size  = 2'd2;
    bus.data_sram_addr  = 32'h40;
    bus.data_sram_wstrb = 4'h0;
    bus.data_sram_wdata = '0;

    // Reset held with a live request.
    repeat (3) begin
      @(negedge clk);
      check("reset_addr_ok", 32'(bus.data_sram_addr_ok), 32'd0);
      check("reset_data_ok", 32'(bus.data_sram_data_ok), 32'd0);
      check("reset_rdata", bus.data_sram_rdata, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.data_sram_req = 1'b0;
    #1;
`ifndef DSRAM_STALL_INJECT_EN
    check("addr_ok_after_reset", 32'(bus.data_sram_addr_ok), 32'd1);
`endif

    // Full-word write then isolated read.
    issue(1'b1, 2'd2, 32'h40, 4'hF, 32'h1234_5678, s0, a0);
    quiesce();
    issue(1'b0, 2'd2, 32'h40, 4'h0, 32'h0, s1, a1);
    quiesce();
    check("s2_rdata", last_rdata, 32'h1234_5678);
    check("s2_latency", 32'(resp_at[s1] - a1), 32'(RESP_LAT + 1));

    // Single byte lane merge.
    issue(1'b1, 2'd0, 32'h42, 4'b0100, 32'hAAAA_AAAA, s0, a0);
    issue(1'b0, 2'd2, 32'h40, 4'h0, 32'h0, s1, a1);
    quiesce();
    check("s3_rdata", last_rdata, 32'h12AA_5678);

    // Three back-to-back reads against a two-entry queue.
    issue(1'b1, 2'd2, 32'h80, 4'hF, 32'h1111_0001, s0, a0);
    issue(1'b1, 2'd2, 32'h84, 4'hF, 32'h2222_0002, s0, a0);
    issue(1'b1, 2'd2, 32'h88, 4'hF, 32'h3333_0003, s0, a0);
    quiesce();
    issue(1'b0, 2'd2, 32'h80, 4'h0, 32'h0, s0, a0);
    issue(1'b0, 2'd2, 32'h84, 4'h0, 32'h0, s1, a1);
    issue(1'b0, 2'd2, 32'h88, 4'h0, 32'h0, s2, a2);
    quiesce();
    check("s4_last_rdata", last_rdata, 32'h3333_0003);
`ifndef DSRAM_STALL_INJECT_EN
    check("s4_second_accept", 32'(a1 - a0), 32'd1);
    check("s4_third_accept", 32'(a2 - resp_at[s0]), 32'd2);
`endif

    // Address aliasing: upper bits and low byte offset ignored.
    issue(1'b0, 2'd2, 32'h0000_1040, 4'h0, 32'h0, s0, a0);
    quiesce();
    check("s5_alias_read", last_rdata, 32'h12AA_5678);
    issue(1'b1, 2'd2, 32'hABCD_1047, 4'hF, 32'hCAFE_F00D, s0, a0);
    issue(1'b0, 2'd2, 32'h44, 4'h0, 32'h0, s1, a1);
    quiesce();
    check("s5_alias_write", last_rdata, 32'hCAFE_F00D);

    // Reset with two reads outstanding: both discarded, memory kept.
    issue(1'b0, 2'd2, 32'h80, 4'h0, 32'h0, s0, a0);
    issue(1'b0, 2'd2, 32'h84, 4'h0, 32'h0, s1, a1);
    @(negedge clk);
    bus.data_sram_req = 1'b0;
    reset = 1'b1;
    sb.delete();
    last_resp = -100;
    spurious = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("s6_no_data_ok", 32'(spurious), 32'd0);
    issue(1'b0, 2'd2, 32'h44, 4'h0, 32'h0, s0, a0);
    quiesce();
    check("s6_kept_44", last_rdata, 32'hCAFE_F00D);
    issue(1'b0, 2'd2, 32'h40, 4'h0, 32'h0, s0, a0);
    quiesce();
    check("s6_kept_40", last_rdata, 32'h12AA_5678);

    // Randomised traffic over eight aliased words.
    for (int i = 0; i < 8; i++)
      issue(1'b1, 2'd2, 32'h400 + 32'(i * 4), 4'hF, $urandom, s0, a0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.data_sram_req = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      k = $urandom_range(0, 7);
      a = ($urandom & 32'hFFFF_F000) | 32'h400 | 32'(k << 2) | ($urandom & 32'h3);
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, 4'($urandom), $urandom, s0, a0);
    end
    quiesce();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
